digit_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder/subtractor: adds DIGIT bits per clock through a registered carry.

---
 rtl/digit_serial_adder.sv | 151 +++++++++++++++
 tb/tb_digit_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock through a registered carry,
// with valid/ready handshakes on both sides and carry-out / signed-overflow reporting.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IDX_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic               accept_s;
  logic               last_dig_s;
  logic [IDX_W-1:0]   digit_base_s;
  logic [DIGIT-1:0]   a_dig_s;
  logic [DIGIT-1:0]   b_dig_s;
  logic [DIGIT+1:0]   add_res_s;

  // Result layout: {carry out, carry into digit MSB, digit sum}. The carry into the MSB
  // is recovered as x^y^s at the top bit, which also works for single-bit digits.
  function automatic logic [DIGIT+1:0] add_digit(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             cin
  );
    logic [DIGIT:0] t;
    t = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    return {t[DIGIT], x[DIGIT-1] ^ y[DIGIT-1] ^ t[DIGIT-1], t[DIGIT-1:0]};
  endfunction

  // Digit datapath: select the current digit of each operand and add it.
  always_comb begin
    accept_s     = in_valid & in_ready_r;
    last_dig_s   = (cnt_r == CNT_W'(NDIG - 1));
    digit_base_s = IDX_W'(cnt_r) * IDX_W'(DIGIT);
    a_dig_s      = a_r[digit_base_s +: DIGIT];
    b_dig_s      = b_r[digit_base_s +: DIGIT];
    add_res_s    = add_digit(a_dig_s, b_dig_s, carry_r);
  end

  // Next-state logic for the IDLE -> CALC -> DONE handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_dig_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_CALC: begin
          sum_r[digit_base_s +: DIGIT] <= add_res_s[DIGIT-1:0];
          carry_r                      <= add_res_s[DIGIT+1];
          if (last_dig_s) begin
            cout_r <= add_res_s[DIGIT+1];
            ovf_r  <= add_res_s[DIGIT+1] ^ add_res_s[DIGIT];
            cnt_r  <= {CNT_W{1'b0}};
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT = 1, 4, 16) checked against a
// signed/unsigned integer arithmetic model, with directed, backpressure, reset and random scenarios.
module tb_digit_serial_adder;

  localparam int W  = 16;
  localparam int NI = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NI-1:0]        in_valid;
  logic [NI-1:0]        in_ready;
  logic [NI-1:0]        sub;
  logic [NI-1:0]        out_valid;
  logic [NI-1:0]        out_ready;
  logic [NI-1:0]        cout;
  logic [NI-1:0]        ovf;
  logic [NI-1:0][W-1:0] a;
  logic [NI-1:0][W-1:0] b;
  logic [NI-1:0][W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
    .sub(sub[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum[0]),
    .cout(cout[0]), .ovf(ovf[0]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
    .sub(sub[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum[1]),
    .cout(cout[1]), .ovf(ovf[1]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a[2]), .b(b[2]),
    .sub(sub[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum[2]),
    .cout(cout[2]), .ovf(ovf[2]));

  function automatic int ndig(input int d);
    if (d == 0) return 16;
    if (d == 1) return 4;
    return 1;
  endfunction

  // Reference: plain integer arithmetic, unsigned for the carry, signed for overflow.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                output logic [W-1:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, r;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    r  = sv ? (sa - sb) : (sa + sb);
    s  = r[W-1:0];
    o  = (r > 32767) || (r < -32768);
    c  = sv ? (ua >= ub) : ((ua + ub) > 65535);
  endfunction

  task automatic run_op(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input string tag);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;
    model(av, bv, sv, es, ec, eo);
    @(negedge clk);
    n_cmp++;
    if (in_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL %s d%0d in_ready_before: got %b want 1", tag, d, in_ready[d]);
    end
    a[d] = av; b[d] = bv; sub[d] = sv; in_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    a[d] = W'($urandom); b[d] = W'($urandom); sub[d] = ~sv;
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != ndig(d)) begin
      n_err++;
      $display("FAIL %s d%0d latency: got %0d want %0d", tag, d, lat, ndig(d));
    end
    n_cmp++;
    if (sum[d] !== es) begin
      n_err++;
      $display("FAIL %s d%0d sum a=%h b=%h sub=%b: got %h want %h", tag, d, av, bv, sv, sum[d], es);
    end
    n_cmp++;
    if (cout[d] !== ec) begin
      n_err++;
      $display("FAIL %s d%0d cout a=%h b=%h sub=%b: got %b want %b", tag, d, av, bv, sv, cout[d], ec);
    end
    n_cmp++;
    if (ovf[d] !== eo) begin
      n_err++;
      $display("FAIL %s d%0d ovf a=%h b=%h sub=%b: got %b want %b", tag, d, av, bv, sv, ovf[d], eo);
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    n_cmp++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL %s d%0d drain: got out_valid=%b in_ready=%b want 0/1", tag, d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '0; out_ready = '0; sub = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      n_cmp++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || sum[d] !== 16'h0000 ||
          cout[d] !== 1'b0 || ovf[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset d%0d: got rdy=%b vld=%b sum=%h c=%b o=%b want 1 0 0000 0 0",
                 d, in_ready[d], out_valid[d], sum[d], cout[d], ovf[d]);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic         ts [6];
    ta = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
    tb = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0005};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 6; i++) begin
        run_op(d, ta[i], tb[i], ts[i], "directed");
      end
    end
  endtask

  task automatic test_backpressure();
    int d;
    int lat;
    d = 1;
    @(negedge clk);
    a[d] = 16'h1234; b[d] = 16'h4321; sub[d] = 1'b0; in_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid[d] = ~in_valid[d];
      a[d] = W'($urandom); b[d] = W'($urandom); sub[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || sum[d] !== 16'h5555 ||
          cout[d] !== 1'b0 || ovf[d] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc%0d: got vld=%b rdy=%b sum=%h c=%b o=%b want 1 0 5555 0 0",
                 i, out_valid[d], in_ready[d], sum[d], cout[d], ovf[d]);
      end
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    n_cmp++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || sum[d] !== 16'h5555) begin
      n_err++;
      $display("FAIL bp_drain: got vld=%b rdy=%b sum=%h want 0 1 5555", out_valid[d], in_ready[d], sum[d]);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_no_new_op: got vld=%b rdy=%b want 0 1", out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset_mid_op();
    int d;
    d = 1;
    @(negedge clk);
    a[d] = 16'h1234; b[d] = 16'h4321; sub[d] = 1'b0; in_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || sum[d] !== 16'h0000 ||
        cout[d] !== 1'b0 || ovf[d] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_op: got vld=%b rdy=%b sum=%h c=%b o=%b want 0 1 0000 0 0",
               out_valid[d], in_ready[d], sum[d], cout[d], ovf[d]);
    end
    run_op(d, 16'h1234, 16'h4321, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 40; i++) begin
        av = W'($urandom);
        bv = W'($urandom);
        if (i % 8 == 0) av = 16'h8000;
        if (i % 8 == 1) bv = 16'hFFFF;
        if (i % 8 == 2) bv = av;
        run_op(d, av, bv, 1'($urandom_range(1, 0)), "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
